// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states and
// datapath mux selects, plus small opcode-classification helpers.
package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;
    localparam logic [1:0] PC_SEL_JALR   = 2'b11;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    // Opcodes that proceed from DECODE into EXEC.
    function automatic logic is_exec_op(input logic [6:0] op);
        case (op)
            R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        case (op)
            I_TYPE, LW, SW, JALR: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_op_for(input logic [6:0] op);
        case (op)
            BR:             return ALU_OP_BRANCH;
            R_TYPE, I_TYPE: return ALU_OP_FUNCT;
            default:        return ALU_OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory handshake watchdog: counts stalled request cycles and raises a sticky error
// once the wait reaches TimeoutCycles (0 disables it).
module mem_watchdog #(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic req_i,
    input  logic ready_i,
    output logic fire_o,
    output logic timeout_err_o
);

    localparam int unsigned CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // A ready in the threshold cycle is a completion, so only a stalled cycle can fire.
    always_comb begin
        cnt_d  = '0;
        err_d  = err_q;
        fire_o = 1'b0;
        if ((TimeoutCycles != 0) && req_i && !ready_i) begin
            if (32'(cnt_q) == TimeoutCycles - 1) begin
                fire_o = 1'b1;
                err_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err_o = err_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the RV32I subset over one shared memory port.
// Define MULTICYCLE_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             instr_fetch,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             timeout_err,
`ifdef MULTICYCLE_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic [2:0]       state_o
);

    if (CNT_W == 0) begin : g_cnt_w_invalid
        $error("CNT_W must be at least 1");
    end

    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       wd_fire;
    logic       wd_timeout_err;

    // Request-side outputs depend on state only, which keeps the watchdog loop acyclic.
    assign mem_req     = ~reset & ((state_q == FETCH) | (state_q == MEM));
    assign mem_we      = ~reset & (state_q == MEM) & (op_q == SW);
    assign instr_fetch = ~reset & (state_q == FETCH);
    assign halted      = ~reset & (state_q == HALT);
    assign timeout_err = ~reset & wd_timeout_err;
    assign state_o     = reset ? 3'b000 : state_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_SEL_PLUS4;
        rf_we   = 1'b0;
        wb_sel  = WB_SEL_ALU;
        alu_src = 1'b0;
        alu_op  = ALU_OP_ADD;

        unique case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op_d = opcode;
                if (opcode == SYSTEM) begin
                    state_d = HALT;
                end else if (!is_exec_op(opcode)) begin
                    pc_we   = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_src = uses_imm(op_q);
                alu_op  = alu_op_for(op_q);
                if (op_q == BR) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                    state_d = FETCH;
                end else if ((op_q == LW) || (op_q == SW)) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (op_q == SW) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (op_q == LW) begin
                    wb_sel = WB_SEL_MEM;
                end else if ((op_q == JAL) || (op_q == JALR)) begin
                    wb_sel = WB_SEL_PC4;
                end
                if (op_q == JAL) begin
                    pc_sel = PC_SEL_JAL;
                end else if (op_q == JALR) begin
                    pc_sel = PC_SEL_JALR;
                end
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (wd_fire) begin
            state_d = HALT;
        end

        if (reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            pc_sel  = PC_SEL_PLUS4;
            rf_we   = 1'b0;
            wb_sel  = WB_SEL_ALU;
            alu_src = 1'b0;
            alu_op  = ALU_OP_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    mem_watchdog #(
        .TimeoutCycles(TIMEOUT_CYCLES)
    ) u_mem_watchdog (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_i        (mem_req),
        .ready_i      (mem_ready),
        .fire_o       (wd_fire),
        .timeout_err_o(wd_timeout_err)
    );

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != HALT) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (pc_we) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner sequences and
// randomized instruction streams checked against a phase-level reference model.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam int NT = 22;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       instr_fetch;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       halted;
        logic       timeout_err;
    } vec_t;

    typedef struct packed {
        logic       rdy;
        logic [6:0] op;
        logic       tk;
        vec_t       e;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, instr_fetch, ir_we, pc_we, rf_we, alu_src, halted, timeout_err;
    logic [1:0] pc_sel, wb_sel, alu_op;
    logic [2:0] state_o;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    cyc_t plan_q[$];
    cyc_t tbl[NT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .branch_taken(branch_taken),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .instr_fetch (instr_fetch),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .halted      (halted),
        .timeout_err (timeout_err),
`ifdef MULTICYCLE_PERF_EN
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
`endif
        .state_o     (state_o)
    );

    function automatic vec_t v(input logic [2:0] st, input logic rq, we, fe, ir, pw,
                               input logic [1:0] ps, input logic rw, input logic [1:0] ws,
                               input logic as, input logic [1:0] ao, input logic h, te);
        vec_t r;
        r = '{st, rq, we, fe, ir, pw, ps, rw, ws, as, ao, h, te};
        return r;
    endfunction

    function automatic cyc_t mk(input logic rdy, input logic [6:0] op, input logic tk,
                                input vec_t e);
        cyc_t c;
        c.rdy = rdy;
        c.op  = op;
        c.tk  = tk;
        c.e   = e;
        return c;
    endfunction

    function automatic vec_t observe();
        vec_t a;
        a = '{state_o, mem_req, mem_we, instr_fetch, ir_we, pc_we, pc_sel, rf_we, wb_sel,
              alu_src, alu_op, halted, timeout_err};
        return a;
    endfunction

    // Selects only matter when their enable is up; ALU controls only matter in EXEC.
    task automatic check_vec(input string tag, input vec_t e, input logic full);
        vec_t a, m;
        a = observe();
        m = '1;
        if (!full) begin
            if (!e.pc_we) m.pc_sel = 2'b00;
            if (!e.rf_we) m.wb_sel = 2'b00;
            if (e.state != 3'd2) begin
                m.alu_src = 1'b0;
                m.alu_op  = 2'b00;
            end
        end
        checks++;
        if ((a & m) == (e & m)) passed++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h, mask %h", tag, cyc, a, e, m);
    endtask

    task automatic step(input cyc_t c, input string tag);
        @(negedge clk);
        reset        = 1'b0;
        mem_ready    = c.rdy;
        opcode       = c.op;
        branch_taken = c.tk;
        #1;
        check_vec(tag, c.e, 1'b0);
    endtask

    task automatic do_reset(input logic rdy, input string tag);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = rdy;
        opcode    = 7'($urandom());
        #1;
        check_vec(tag, '0, 1'b1);
        @(negedge clk);
        #1;
        check_vec(tag, '0, 1'b1);
    endtask

    function automatic logic [6:0] rand_unknown();
        logic [6:0] u;
        do u = 7'($urandom());
        while (u inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_SYS});
        return u;
    endfunction

    // Reference model: one instruction as a list of phases, each phase a run of cycles.
    task automatic plan_instr(input logic [6:0] op, input logic tk, input int wf, input int wm);
        vec_t e;
        logic known;
        known = op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
        for (int i = 0; i <= wf; i++) begin
            e = '0;
            e.mem_req = 1'b1;
            e.instr_fetch = 1'b1;
            e.ir_we = (i == wf);
            plan_q.push_back(mk(i == wf, 7'($urandom()), 1'($urandom()), e));
        end
        e = '0;
        e.state = 3'd1;
        e.pc_we = !known;
        plan_q.push_back(mk(1'($urandom()), op, 1'($urandom()), e));
        if (!known) return;
        e = '0;
        e.state = 3'd2;
        e.alu_src = op inside {OP_I, OP_LW, OP_SW, OP_JALR};
        e.alu_op = (op == OP_BR) ? 2'b01 : (op inside {OP_R, OP_I}) ? 2'b10 : 2'b00;
        if (op == OP_BR) begin
            e.pc_we = 1'b1;
            e.pc_sel = tk ? 2'b01 : 2'b00;
        end
        plan_q.push_back(mk(1'($urandom()), 7'($urandom()), (op == OP_BR) ? tk : 1'($urandom()), e));
        if (op == OP_BR) return;
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i <= wm; i++) begin
                e = '0;
                e.state = 3'd3;
                e.mem_req = 1'b1;
                e.mem_we = (op == OP_SW);
                e.pc_we = (op == OP_SW) && (i == wm);
                plan_q.push_back(mk(i == wm, 7'($urandom()), 1'($urandom()), e));
            end
        end
        if (op == OP_SW) return;
        e = '0;
        e.state = 3'd4;
        e.rf_we = 1'b1;
        e.pc_we = 1'b1;
        e.wb_sel = (op == OP_LW) ? 2'b01 : (op inside {OP_JAL, OP_JALR}) ? 2'b10 : 2'b00;
        e.pc_sel = (op == OP_JAL) ? 2'b10 : (op == OP_JALR) ? 2'b11 : 2'b00;
        plan_q.push_back(mk(1'($urandom()), 7'($urandom()), 1'($urandom()), e));
    endtask

    initial begin
        vec_t f_ir, f_wait, dec, mem_w, halt_v, halt_t;
        logic [6:0] ops[7];
        logic [6:0] op;
        int idx;

        f_ir   = v(3'd0, 1, 0, 1, 1, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
        f_wait = v(3'd0, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
        dec    = v(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
        mem_w  = v(3'd3, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
        halt_v = v(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 0);
        halt_t = v(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 1);
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};

        // add, zero-wait; junk opcode outside DECODE must be ignored
        tbl[0]  = mk(1, OP_SYS, 0, f_ir);
        tbl[1]  = mk(1, OP_R, 0, dec);
        tbl[2]  = mk(1, OP_SYS, 1, v(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd2, 0, 0));
        tbl[3]  = mk(1, OP_SYS, 0, v(3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 0, 2'd0, 0, 0));
        // lw, memory phase ready after 3 wait cycles
        tbl[4]  = mk(1, OP_SYS, 0, f_ir);
        tbl[5]  = mk(0, OP_LW, 0, dec);
        tbl[6]  = mk(1, OP_SYS, 0, v(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd0, 0, 0));
        tbl[7]  = mk(0, OP_SYS, 0, mem_w);
        tbl[8]  = mk(0, OP_SYS, 0, mem_w);
        tbl[9]  = mk(0, OP_SYS, 0, mem_w);
        tbl[10] = mk(1, OP_SYS, 0, mem_w);
        tbl[11] = mk(0, OP_SYS, 0, v(3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 0, 2'd0, 0, 0));
        // beq taken, then not taken
        tbl[12] = mk(1, OP_SYS, 0, f_ir);
        tbl[13] = mk(1, OP_BR, 0, dec);
        tbl[14] = mk(0, OP_SYS, 1, v(3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 0, 2'd1, 0, 0));
        tbl[15] = mk(1, OP_SYS, 1, f_ir);
        tbl[16] = mk(1, OP_BR, 1, dec);
        tbl[17] = mk(1, OP_SYS, 0, v(3'd2, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0, 2'd1, 0, 0));
        // jalr
        tbl[18] = mk(1, OP_SYS, 0, f_ir);
        tbl[19] = mk(1, OP_JALR, 0, dec);
        tbl[20] = mk(0, OP_SYS, 0, v(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd0, 0, 0));
        tbl[21] = mk(1, OP_SYS, 0, v(3'd4, 0, 0, 0, 0, 1, 2'd3, 1, 2'd2, 0, 2'd0, 0, 0));

        do_reset(1'b1, "reset");
        for (int i = 0; i < NT; i++) step(tbl[i], $sformatf("table[%0d]", i));

        // Watchdog: fetch stalls 4 cycles, then HALT with sticky error until reset
        for (int i = 0; i < 4; i++) step(mk(0, OP_R, 0, f_wait), $sformatf("tmo_wait%0d", i));
        for (int i = 0; i < 4; i++) begin
            step(mk(1'($urandom()), 7'($urandom()), 0, halt_t), $sformatf("tmo_halt%0d", i));
        end
        do_reset(1'b0, "tmo_reset");
        step(mk(0, OP_R, 0, f_wait), "tmo_refetch");
        step(mk(1, OP_R, 0, f_ir), "tmo_refetch_ir");

        // Halt opcode is absorbing
        step(mk(1, OP_SYS, 0, dec), "halt_decode");
        for (int i = 0; i < 20; i++) begin
            step(mk(1'($urandom()), 7'($urandom()), 1'($urandom()), halt_v), $sformatf("halt%0d", i));
        end

        // Reset during a stalled lw memory phase, with ready arriving in the reset cycle
        do_reset(1'b0, "halt_reset");
        step(mk(1, OP_R, 0, f_ir), "mid_f");
        step(mk(0, OP_LW, 0, dec), "mid_d");
        step(mk(0, OP_R, 0, v(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd0, 0, 0)), "mid_e");
        step(mk(0, OP_R, 0, mem_w), "mid_m0");
        step(mk(0, OP_R, 0, mem_w), "mid_m1");
        do_reset(1'b1, "mid_reset");
        step(mk(0, OP_R, 0, f_wait), "mid_refetch");
        step(mk(1, OP_R, 0, f_ir), "mid_refetch_ir");
        step(mk(0, 7'b0000000, 0, v(3'd1, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0)), "nop");

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, 7);
            op = (idx == 7) ? rand_unknown() : ops[idx];
            plan_instr(op, 1'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3));
            while (plan_q.size() > 0) step(plan_q.pop_front(), $sformatf("rand%0d op=%b", n, op));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
